// File: rtl/gpio_seq_ctrl.sv
// gpio_seq_ctrl: arbitrates two command requesters and a periodic edge-capture poll onto a GPIO slave port.
module gpio_seq_ctrl #(
  parameter int POLL_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  output logic        rsp0_valid,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  input  logic        poll_en,
  output logic        edge_valid,
  output logic [31:0] edge_flags,
  output logic        busy
);
  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD_ADDR = 3'd2, RD_CAP = 3'd3,
                         POLL_RD = 3'd4, POLL_CAP = 3'd5, POLL_CLR = 3'd6;
  localparam logic [15:0] RELOAD = 16'(POLL_PERIOD - 1);
  logic [2:0]  state, state_n;
  logic        who, rr, poll_pending, idle, g_poll, g0, g1;
  logic [1:0]  op_q, req_op;
  logic [31:0] data_q;
  logic [15:0] timer;
  // rr set means req1 holds priority at the next contention
  always_comb begin
    idle   = (state == IDLE) && reset_n;
    g_poll = idle && poll_pending;
    g0     = idle && !poll_pending && req0_valid && (!req1_valid || !rr);
    g1     = idle && !poll_pending && req1_valid && (!req0_valid || rr);
    req_op = g1 ? req1_op : req0_op;
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:     state_n = g_poll ? POLL_RD : (g0 || g1) ? (req_op == 2'd3 ? RD_ADDR : WR) : IDLE;
      RD_ADDR:  state_n = RD_CAP;
      POLL_RD:  state_n = POLL_CAP;
      POLL_CAP: state_n = (|m_readdata) ? POLL_CLR : IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    m_chipselect = (state == WR) || (state == RD_ADDR) || (state == POLL_RD) || (state == POLL_CLR);
    m_write_n    = !((state == WR) || (state == POLL_CLR));
    m_address    = (state == WR) ? (op_q == 2'd1 ? 3'd4 : op_q == 2'd2 ? 3'd5 : 3'd0) :
                   ((state == POLL_RD) || (state == POLL_CLR)) ? 3'd3 : 3'd0;
    m_writedata  = (state == WR) ? data_q : (state == POLL_CLR) ? 32'hFFFF_FFFF : 32'd0;
    busy         = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      who          <= 1'b0;
      rr           <= 1'b0;
      op_q         <= 2'd0;
      data_q       <= 32'd0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp_data     <= 32'd0;
      edge_valid   <= 1'b0;
      edge_flags   <= 32'd0;
      poll_pending <= 1'b0;
      timer        <= RELOAD;
    end else begin
      state <= state_n;
      if (g0 || g1) begin
        who    <= g1;
        rr     <= g0;
        op_q   <= req_op;
        data_q <= g1 ? req1_data : req0_data;
      end
      rsp0_valid <= ((state == WR) || (state == RD_CAP)) && !who;
      rsp1_valid <= ((state == WR) || (state == RD_CAP)) && who;
      if (state == WR) rsp_data <= 32'd0;
      else if (state == RD_CAP) rsp_data <= m_readdata;
      edge_valid <= state == POLL_CLR;
      if (state == POLL_CAP && |m_readdata) edge_flags <= m_readdata;
      // an expiry in the same cycle as the poll grant re-arms the pending flag
      timer        <= (!poll_en || timer == 16'd0) ? RELOAD : timer - 16'd1;
      poll_pending <= !poll_en ? 1'b0 : (timer == 16'd0) ? 1'b1 : g_poll ? 1'b0 : poll_pending;
    end
  end
endmodule
